// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: three-source fixed-priority interrupt controller.
// Source 3 has the highest priority and source 1 the lowest. Rising edges on
// the break inputs latch pending flags (IW). The highest eligible source is
// presented to the CPU together with its vector. An int_ack/eret handshake
// tracks the in-service flags (ir).
// Optional feature: define INT_NEST_EN to allow nested service. A
// higher-priority source can then interrupt one that is already in service.
// Without it, every request waits until nothing is in service.
module int_priority_ctrl #(
    parameter logic [11:0] VEC1 = 12'h100,
    parameter logic [11:0] VEC2 = 12'h200,
    parameter logic [11:0] VEC3 = 12'h300
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        break1,
    input  logic        break2,
    input  logic        break3,
    input  logic        mask_we,
    input  logic [2:0]  mask_in,
    input  logic        int_ack,
    input  logic        eret,
    output logic        interrupt,
    output logic [11:0] int_vec,
    output logic        IW1,
    output logic        IW2,
    output logic        IW3,
    output logic        ir1_sig,
    output logic        ir2_sig,
    output logic        ir3_sig
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] brk_q;
    logic [2:0] iw_q, iw_d;
    logic [2:0] ir_q, ir_d;
    logic [2:0] mask_q, mask_d;

    logic [2:0] brk_now;
    logic [2:0] rise;
    logic [1:0] level;
    logic [2:0] above;
    logic [2:0] eligible;
    logic       ack_take;

    // Index of the highest set bit (3 = bit 2), 0 when no bit is set.
    function automatic logic [1:0] top_idx(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    // One-hot source bit for a source index; index 0 means no source.
    function automatic logic [2:0] idx_to_oh(input logic [1:0] idx);
        case (idx)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign brk_now = {break3, break2, break1};
    assign rise    = brk_now & ~brk_q;
    assign level   = top_idx(ir_q);
    assign above   = {level < 2'd3, level < 2'd2, level < 2'd1};

`ifdef INT_NEST_EN
    assign eligible = iw_q & ~mask_q & above;
`else
    assign eligible = iw_q & ~mask_q & above & {3{ir_q == 3'b000}};
`endif

    // State register. Reset clears all control state and resamples the break
    // levels, so a level held through reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            brk_q   <= brk_now;
            iw_q    <= 3'b000;
            ir_q    <= 3'b000;
            mask_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            brk_q   <= brk_now;
            iw_q    <= iw_d;
            ir_q    <= ir_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state logic. sel is latched only when a request starts, so it
    // stays frozen for the whole REQ period.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    sel_d   = top_idx(eligible);
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d  = IDLE;
                    ack_take = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending, in-service and mask updates. A new edge overrides an ack
    // clear on the same source. eret retires the level that was active
    // before this edge, and then the acknowledged source enters service.
    always_comb begin
        iw_d   = (iw_q & ~(ack_take ? idx_to_oh(sel_q) : 3'b000)) | rise;
        ir_d   = (ir_q & ~(eret ? idx_to_oh(level) : 3'b000))
                 | (ack_take ? idx_to_oh(sel_q) : 3'b000);
        mask_d = mask_we ? mask_in : mask_q;
    end

    // Outputs are decoded only from registered state.
    always_comb begin
        interrupt = (state_q == REQ);
        int_vec   = 12'h000;
        if (state_q == REQ) begin
            case (sel_q)
                2'd1:    int_vec = VEC1;
                2'd2:    int_vec = VEC2;
                2'd3:    int_vec = VEC3;
                default: int_vec = 12'h000;
            endcase
        end
    end

    assign IW1     = iw_q[0];
    assign IW2     = iw_q[1];
    assign IW3     = iw_q[2];
    assign ir1_sig = ir_q[0];
    assign ir2_sig = ir_q[1];
    assign ir3_sig = ir_q[2];

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Table-driven bench for int_priority_ctrl. Each record gives the inputs
// applied before a clock edge and the outputs expected after that edge.
module tb_int_priority_ctrl;

    typedef struct {
        logic        rst;
        logic [2:0]  brk;
        logic        mwe;
        logic [2:0]  min;
        logic        ack;
        logic        eret;
        logic        intr;
        logic [11:0] vec;
        logic [2:0]  iw;
        logic [2:0]  ir;
    } vec_t;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        break1 = 1'b0, break2 = 1'b0, break3 = 1'b0;
    logic        mask_we = 1'b0;
    logic [2:0]  mask_in = 3'b000;
    logic        int_ack = 1'b0;
    logic        eret = 1'b0;
    logic        interrupt;
    logic [11:0] int_vec;
    logic        IW1, IW2, IW3, ir1_sig, ir2_sig, ir3_sig;

    int pass_cnt = 0;
    int total_cnt = 0;

    vec_t tbl[$];
    vec_t seq[$];

    int_priority_ctrl dut (
        .clk(clk), .RST(RST),
        .break1(break1), .break2(break2), .break3(break3),
        .mask_we(mask_we), .mask_in(mask_in),
        .int_ack(int_ack), .eret(eret),
        .interrupt(interrupt), .int_vec(int_vec),
        .IW1(IW1), .IW2(IW2), .IW3(IW3),
        .ir1_sig(ir1_sig), .ir2_sig(ir2_sig), .ir3_sig(ir3_sig)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [2:0] brk,
                                input logic mwe, input logic [2:0] min,
                                input logic ack, input logic er,
                                input logic intr, input logic [11:0] vec,
                                input logic [2:0] iw, input logic [2:0] ir);
        vec_t v;
        v.rst = rst; v.brk = brk; v.mwe = mwe; v.min = min;
        v.ack = ack; v.eret = er; v.intr = intr; v.vec = vec;
        v.iw = iw; v.ir = ir;
        return v;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic run(input vec_t v, input string tag, input int row);
        RST = v.rst;
        {break3, break2, break1} = v.brk;
        mask_we = v.mwe;
        mask_in = v.min;
        int_ack = v.ack;
        eret = v.eret;
        @(posedge clk);
        #1;
        check({tag, ".interrupt"}, row, {11'd0, interrupt}, {11'd0, v.intr});
        check({tag, ".int_vec"}, row, int_vec, v.vec);
        check({tag, ".IW"}, row, {9'd0, IW3, IW2, IW1}, {9'd0, v.iw});
        check({tag, ".ir"}, row, {9'd0, ir3_sig, ir2_sig, ir1_sig}, {9'd0, v.ir});
    endtask

    initial begin
        //                rst brk     mwe min    ack er  intr vec      iw      ir
        // reset, then single break2 request
        tbl.push_back(mk(1, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h200, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h200, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b010));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b000, 3'b010));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
        // all three breaks together: served 3, 2, 1
        tbl.push_back(mk(0, 3'b111, 0, 3'b000, 0, 0, 0, 12'h000, 3'b111, 3'b000));
        tbl.push_back(mk(0, 3'b111, 0, 3'b000, 0, 0, 1, 12'h300, 3'b111, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b011, 3'b100));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b011, 3'b100));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b011, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h200, 3'b011, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b001, 3'b010));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b001, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h100, 3'b001, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b001));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
        // ack in IDLE and eret with nothing in service are ignored
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
        // source 2 request, then a new break2 edge on the ack edge keeps IW2
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h200, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 0, 0, 12'h000, 3'b010, 3'b010));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b010));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h200, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b010));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
        // mask source 2: it latches IW but does not request until unmasked
        tbl.push_back(mk(0, 3'b000, 1, 3'b010, 0, 0, 0, 12'h000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, 0, 12'h000, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h200, 3'b010, 3'b000));
        // a mask write during REQ does not withdraw the request
        tbl.push_back(mk(0, 3'b000, 1, 3'b010, 0, 0, 1, 12'h200, 3'b010, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b010));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
        // reset during REQ with break3 held high through it
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 0, 0, 0, 12'h000, 3'b100, 3'b000));
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 0, 0, 1, 12'h300, 3'b100, 3'b000));
        tbl.push_back(mk(1, 3'b100, 0, 3'b000, 0, 0, 0, 12'h000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 0, 0, 0, 12'h000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b100, 0, 3'b000, 0, 0, 0, 12'h000, 3'b000, 3'b000));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b000, 3'b000));

        // source 1 in service, then source 3 arrives
        seq.push_back(mk(0, 3'b001, 0, 3'b000, 0, 0, 0, 12'h000, 3'b001, 3'b000));
        seq.push_back(mk(0, 3'b001, 0, 3'b000, 0, 0, 1, 12'h100, 3'b001, 3'b000));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b001));
        seq.push_back(mk(0, 3'b100, 0, 3'b000, 0, 0, 0, 12'h000, 3'b100, 3'b001));
`ifdef INT_NEST_EN
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h300, 3'b100, 3'b001));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b101));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b001));
        // nested request again, then eret and ack on the same edge
        seq.push_back(mk(0, 3'b100, 0, 3'b000, 0, 0, 0, 12'h000, 3'b100, 3'b001));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h300, 3'b100, 3'b001));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 1, 1, 0, 12'h000, 3'b000, 3'b100));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
`else
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b100, 3'b001));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 12'h000, 3'b100, 3'b001));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b100, 3'b000));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 12'h300, 3'b100, 3'b000));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 1, 0, 0, 12'h000, 3'b000, 3'b100));
        seq.push_back(mk(0, 3'b000, 0, 3'b000, 0, 1, 0, 12'h000, 3'b000, 3'b000));
`endif

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], "tbl", i);
        for (int i = 0; i < seq.size(); i++) run(seq[i], "nest", i);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
